// File: rtl/seq_pkg.sv
// Shared types and helpers for the program sequencer: FSM state encoding,
// default address width and jump/call target formation.
package seq_pkg;

   localparam int unsigned PC_W_DEF = 8;

   typedef enum logic [1:0] {
      BOOT  = 2'd0,
      RUN   = 2'd1,
      HOLD  = 2'd2,
      FAULT = 2'd3
   } seq_state_e;

   // Jump/call target: nibble in the top four bits, zeros below.
   function automatic logic [31:0] target_addr(input logic [3:0] nibble,
                                               input int unsigned pc_w);
      return 32'(nibble) << (pc_w - 4);
   endfunction

endpackage

// File: rtl/program_sequencer_if.sv
// Decoder/ALU control inputs and program-memory address/status outputs of the sequencer.
interface program_sequencer_if #(
   parameter int unsigned PC_W = seq_pkg::PC_W_DEF
) ();

   logic            hold;
   logic            jmp;
   logic            jmp_nz;
   logic            dont_jmp;
   logic [3:0]      ir_nibble;
   logic            call;
   logic            ret;
   logic [PC_W-1:0] pm_addr;
   logic [PC_W-1:0] pc;
   logic            fetch_valid;
   logic            stack_ovf;
   logic            stack_unf;

   // Decoder / control side.
   modport master (
      output hold, jmp, jmp_nz, dont_jmp, ir_nibble, call, ret,
      input  pm_addr, pc, fetch_valid, stack_ovf, stack_unf
   );

   // Sequencer side.
   modport slave (
      input  hold, jmp, jmp_nz, dont_jmp, ir_nibble, call, ret,
      output pm_addr, pc, fetch_valid, stack_ovf, stack_unf
   );

endinterface

// File: rtl/ras_stack.sv
// Return-address LIFO. Pointer counts 0..DEPTH; push writes at the pointer,
// pop reads the entry just below it. Contents are not reset.
module ras_stack #(
   parameter int unsigned W     = 8,
   parameter int unsigned DEPTH = 4
) (
   input  logic         clk,
   input  logic         reset_n,
   input  logic         push,
   input  logic         pop,
   input  logic [W-1:0] din,
   output logic [W-1:0] dout,
   output logic         full,
   output logic         empty
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned PW = AW + 1;

   logic [PW-1:0] ptr;
   logic [PW-1:0] ptr_m1;
   logic [W-1:0]  mem [DEPTH];

   assign ptr_m1 = ptr - PW'(1);
   assign full   = (ptr == PW'(DEPTH));
   assign empty  = (ptr == '0);
   assign dout   = mem[ptr_m1[AW-1:0]];

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         ptr <= '0;
      end else if (push && !full) begin
         ptr <= ptr + PW'(1);
      end else if (pop && !empty) begin
         ptr <= ptr_m1;
      end
   end

   always_ff @(posedge clk) begin
      if (push && !full) begin
         mem[ptr[AW-1:0]] <= din;
      end
   end

endmodule

// File: rtl/program_sequencer.sv
// Program counter, next-PC selection and return-address stack control with
// boot, stall and sticky stack-fault states.
module program_sequencer
   import seq_pkg::*;
#(
   parameter int unsigned PC_W        = PC_W_DEF,
   parameter int unsigned STACK_DEPTH = 4,
   parameter int unsigned RESET_VEC   = 0
) (
   input logic                clk,
   input logic                reset_n,
   program_sequencer_if.slave bus
);

   seq_state_e      state_q, state_d;
   logic [PC_W-1:0] pc_q, pc_d;
   logic            ovf_q, ovf_d;
   logic            unf_q, unf_d;
   logic            fv_q, fv_d;

   logic [PC_W-1:0] pc_inc;
   logic [PC_W-1:0] target;
   logic [PC_W-1:0] stk_dout;
   logic            stk_full;
   logic            stk_empty;
   logic            push;
   logic            pop;
   logic            take_jump;

   assign pc_inc    = pc_q + PC_W'(1);
   assign target    = PC_W'(target_addr(bus.ir_nibble, PC_W));
   assign take_jump = bus.jmp || (bus.jmp_nz && !bus.dont_jmp);

   ras_stack #(
      .W     (PC_W),
      .DEPTH (STACK_DEPTH)
   ) u_ras (
      .clk     (clk),
      .reset_n (reset_n),
      .push    (push),
      .pop     (pop),
      .din     (pc_inc),
      .dout    (stk_dout),
      .full    (stk_full),
      .empty   (stk_empty)
   );

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= BOOT;
         pc_q    <= PC_W'(RESET_VEC);
         ovf_q   <= 1'b0;
         unf_q   <= 1'b0;
         fv_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         ovf_q   <= ovf_d;
         unf_q   <= unf_d;
         fv_q    <= fv_d;
      end
   end

   // Next state / next PC; ret outranks call, call outranks jumps.
   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      ovf_d   = ovf_q;
      unf_d   = unf_q;
      push    = 1'b0;
      pop     = 1'b0;

      case (state_q)
         BOOT: begin
            state_d = bus.hold ? HOLD : RUN;
         end
         RUN: begin
            if (bus.hold) begin
               state_d = HOLD;
            end else if (bus.ret) begin
               if (stk_empty) begin
                  unf_d   = 1'b1;
                  state_d = FAULT;
               end else begin
                  pop  = 1'b1;
                  pc_d = stk_dout;
               end
            end else if (bus.call) begin
               if (stk_full) begin
                  ovf_d   = 1'b1;
                  state_d = FAULT;
               end else begin
                  push = 1'b1;
                  pc_d = target;
               end
            end else if (take_jump) begin
               pc_d = target;
            end else begin
               pc_d = pc_inc;
            end
         end
         HOLD: begin
            if (!bus.hold) begin
               state_d = RUN;
            end
         end
         FAULT: begin
            state_d = FAULT;
         end
         default: begin
            state_d = BOOT;
         end
      endcase

      fv_d = (state_d == RUN);
   end

   assign bus.pm_addr     = pc_q;
   assign bus.pc          = pc_q;
   assign bus.fetch_valid = fv_q;
   assign bus.stack_ovf   = ovf_q;
   assign bus.stack_unf   = unf_q;

endmodule

// File: tb/tb_program_sequencer.sv
// Directed test of program_sequencer: boot, jumps, call/return nesting,
// stack overflow/underflow faults, stall and PC wrap.
module tb_program_sequencer;
   import seq_pkg::*;

   logic clk = 1'b0;
   logic reset_n;

   always #5 clk = ~clk;

   program_sequencer_if #(.PC_W(8)) bus ();

   program_sequencer #(
      .PC_W        (8),
      .STACK_DEPTH (4),
      .RESET_VEC   (0)
   ) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus)
   );

   int total = 0;
   int bad   = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clr();
      bus.hold      = 1'b0;
      bus.jmp       = 1'b0;
      bus.jmp_nz    = 1'b0;
      bus.dont_jmp  = 1'b0;
      bus.ir_nibble = 4'h0;
      bus.call      = 1'b0;
      bus.ret       = 1'b0;
   endtask

   task automatic expect_run(input string tag, input logic [7:0] pc_exp);
      check(tag, bus.pc, pc_exp);
      check({tag, "_addr"}, bus.pm_addr, pc_exp);
      check({tag, "_fv"}, bus.fetch_valid, 1'b1);
   endtask

   // Async reset, check reset values, then pass through BOOT into RUN at pc=0.
   task automatic do_reset();
      clr();
      reset_n = 1'b0;
      #2;
      check("rst_pc", bus.pc, 8'h00);
      check("rst_fv", bus.fetch_valid, 1'b0);
      check("rst_ovf", bus.stack_ovf, 1'b0);
      check("rst_unf", bus.stack_unf, 1'b0);
      tick();
      reset_n = 1'b1;
      check("boot_pc", bus.pc, 8'h00);
      check("boot_fv", bus.fetch_valid, 1'b0);
      tick();
      expect_run("run0", 8'h00);
   endtask

   // From RUN: jump to the high nibble, then step to the low nibble.
   task automatic goto_pc(input logic [7:0] addr);
      bus.jmp       = 1'b1;
      bus.ir_nibble = addr[7:4];
      tick();
      clr();
      for (int i = 0; i < int'(addr[3:0]); i++) tick();
      check("goto", bus.pc, addr);
   endtask

   task automatic do_call(input logic [3:0] nib, input logic [7:0] pc_exp);
      bus.call      = 1'b1;
      bus.ir_nibble = nib;
      tick();
      clr();
      expect_run("call", pc_exp);
   endtask

   task automatic do_ret(input logic [7:0] pc_exp);
      bus.ret = 1'b1;
      tick();
      clr();
      expect_run("ret", pc_exp);
   endtask

   initial begin
      reset_n = 1'b1;
      clr();
      #2;

      // Reset, boot, sequential fetch
      do_reset();
      tick(); expect_run("seq1", 8'h01);
      tick(); expect_run("seq2", 8'h02);
      tick(); expect_run("seq3", 8'h03);

      // Unconditional jump at 0x05
      goto_pc(8'h05);
      bus.jmp = 1'b1; bus.ir_nibble = 4'hA;
      tick(); clr();
      expect_run("jmp_a0", 8'hA0);
      tick(); expect_run("jmp_a1", 8'hA1);

      // Conditional jump suppressed, then taken, then jmp+jmp_nz with dont_jmp
      goto_pc(8'h05);
      bus.jmp_nz = 1'b1; bus.dont_jmp = 1'b1; bus.ir_nibble = 4'hA;
      tick(); clr();
      expect_run("jnz_skip", 8'h06);
      bus.jmp_nz = 1'b1; bus.ir_nibble = 4'hB;
      tick(); clr();
      expect_run("jnz_take", 8'hB0);
      bus.jmp = 1'b1; bus.jmp_nz = 1'b1; bus.dont_jmp = 1'b1; bus.ir_nibble = 4'hC;
      tick(); clr();
      expect_run("jmp_both", 8'hC0);

      // Call at 0x10, run to 0x34, return to 0x11
      goto_pc(8'h10);
      do_call(4'h3, 8'h30);
      repeat (4) tick();
      check("sub_pc", bus.pc, 8'h34);
      do_ret(8'h11);

      // ret and call together: ret wins, no push
      do_call(4'h4, 8'h40);
      bus.ret = 1'b1; bus.call = 1'b1; bus.ir_nibble = 4'h5;
      tick(); clr();
      expect_run("ret_over_call", 8'h12);
      bus.ret = 1'b1;
      tick(); clr();
      check("stack_empty_unf", bus.stack_unf, 1'b1);
      check("stack_empty_pc", bus.pc, 8'h12);

      // Nested calls to depth 4, LIFO returns
      do_reset();
      do_call(4'h1, 8'h10);
      do_call(4'h2, 8'h20);
      do_call(4'h3, 8'h30);
      do_call(4'h4, 8'h40);
      do_ret(8'h31);
      do_ret(8'h21);
      do_ret(8'h11);
      do_ret(8'h01);

      // Overflow: fifth call faults, PC frozen regardless of controls
      do_call(4'h1, 8'h10);
      do_call(4'h2, 8'h20);
      do_call(4'h3, 8'h30);
      do_call(4'h4, 8'h40);
      bus.call = 1'b1; bus.ir_nibble = 4'h5;
      tick(); clr();
      check("ovf_flag", bus.stack_ovf, 1'b1);
      check("ovf_unf", bus.stack_unf, 1'b0);
      check("ovf_pc", bus.pc, 8'h40);
      check("ovf_fv", bus.fetch_valid, 1'b0);
      for (int i = 0; i < 20; i++) begin
         bus.jmp = 1'b1; bus.ret = 1'b1; bus.call = i[0];
         bus.hold = i[1]; bus.ir_nibble = 4'h7;
         tick();
         check("fault_pc", bus.pc, 8'h40);
         check("fault_fv", bus.fetch_valid, 1'b0);
      end
      clr();
      tick();
      check("fault_stuck", bus.pc, 8'h40);
      check("fault_ovf", bus.stack_ovf, 1'b1);
      do_reset();

      // Underflow at 0x07
      goto_pc(8'h07);
      bus.ret = 1'b1;
      tick(); clr();
      check("unf_flag", bus.stack_unf, 1'b1);
      check("unf_ovf", bus.stack_ovf, 1'b0);
      check("unf_pc", bus.pc, 8'h07);
      check("unf_fv", bus.fetch_valid, 1'b0);
      tick();
      check("unf_stuck", bus.pc, 8'h07);

      // Hold at 0xFF for 3 cycles, then wrap to 0x00
      do_reset();
      goto_pc(8'hFF);
      bus.hold = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         check("hold_pc", bus.pc, 8'hFF);
         check("hold_fv", bus.fetch_valid, 1'b0);
      end
      bus.hold = 1'b0;
      tick(); expect_run("unhold", 8'hFF);
      tick(); expect_run("wrap", 8'h00);
      check("wrap_ovf", bus.stack_ovf, 1'b0);
      check("wrap_unf", bus.stack_unf, 1'b0);

      // hold with jmp: jump ignored
      bus.hold = 1'b1; bus.jmp = 1'b1; bus.ir_nibble = 4'hA;
      tick();
      check("hold_jmp_pc", bus.pc, 8'h00);
      check("hold_jmp_fv", bus.fetch_valid, 1'b0);
      clr();
      tick(); expect_run("hold_jmp_run", 8'h00);
      tick(); expect_run("hold_jmp_next", 8'h01);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/program_sequencer.md
Name: program_sequencer

Overview:
- Upstream of the instruction decoder. Owns the program counter (PC) and drives the program-memory address; pm_data returned from that address feeds the decoder's instruction register.
- Consumes the decoder's jmp, jmp_nz and ir_nibble, the ALU zero-condition (dont_jmp), and planned call/ret decode outputs.
- Provides a small return-address stack, a stall input and a sticky fault state.

Parameters:
- PC_W, 8, PC / program-memory address width (must be >= 5)
- STACK_DEPTH, 4, return-address stack entries (power of 2, >= 2)
- RESET_VEC, 0, PC value loaded at reset

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous, active-low reset
- hold  in  1  stall: freeze PC and stack; decoder ir is held by the same signal
- jmp  in  1  unconditional jump (from decoder)
- jmp_nz  in  1  conditional jump (from decoder)
- dont_jmp  in  1  ALU condition; 1 suppresses jmp_nz
- ir_nibble  in  4  jump/call target high nibble (from decoder)
- call  in  1  call: jump to target and push return address
- ret  in  1  return: pop return address into PC
- pm_addr  out  PC_W  program-memory read address (= pc, combinational)
- pc  out  PC_W  current PC register
- fetch_valid  out  1  pm_data at pm_addr is a real fetch this cycle
- stack_ovf  out  1  sticky: push while stack full
- stack_unf  out  1  sticky: pop while stack empty

Behaviour:
- Reset (async, reset_n=0): pc=RESET_VEC, stack pointer=0, stack_ovf=0, stack_unf=0, fetch_valid=0, state=BOOT. Stack contents are don't-care.
- FSM states: BOOT, RUN, HOLD, FAULT.
- BOOT: exactly one cycle after reset release. pc holds RESET_VEC, fetch_valid=0, control inputs ignored. Next state is RUN, or HOLD if hold=1.
- RUN: fetch_valid=1. Next-PC priority, highest first:
  - hold=1: pc unchanged; go to HOLD; all control inputs ignored this cycle.
  - ret=1: if stack empty, set stack_unf and go to FAULT with pc unchanged; else pc=top entry and pop. If ret and call are both 1, ret wins and call is ignored.
  - call=1: if stack full, set stack_ovf and go to FAULT with pc unchanged; else push pc+1 and pc=target.
  - jmp=1, or (jmp_nz=1 and dont_jmp=0): pc=target.
  - otherwise: pc=pc+1, wrapping modulo 2^PC_W (all-ones -> 0, no flag).
- target = {ir_nibble, (PC_W-4) zero bits}.
- Delay slot (architectural): the instruction after any jump/call/ret always executes. Control seen in ir at cycle t redirects pm_addr at cycle t+1. The pushed pc+1 is the address after the delay slot.
- HOLD: fetch_valid=0; pc and stack frozen; control inputs ignored. Return to RUN on the first cycle with hold=0; no fetch is lost.
- FAULT: pc, stack and flags frozen; fetch_valid=0; hold ignored. Exit only via reset_n.
- jmp and jmp_nz both high: treated as an unconditional jump.
- Reset asserted mid-operation (any state, including FAULT or HOLD): immediate asynchronous return to the reset values; an in-flight push or pop is discarded.
- Stack is LIFO with pointer 0..STACK_DEPTH: full when pointer=STACK_DEPTH, empty when pointer=0. Push writes the entry at the pointer then increments; pop decrements then reads.
- All outputs except pm_addr are registered; pm_addr=pc with no added latency.

Decomposition:
- Package seq_pkg:
  - state enum {BOOT, RUN, HOLD, FAULT}
  - PC_W default constant
  - target-address helper function
- Sub-module ras_stack (return-address stack): inputs push, pop, din; outputs dout, full, empty.
- The FSM and next-PC mux stay in program_sequencer.

Test Plan:
- Reset and boot: release reset_n, no controls -> BOOT for 1 cycle with pc=0, fetch_valid=0; then pc=1,2,3 on successive cycles.
- Jump: jmp=1, ir_nibble=4'hA at pc=0x05 -> next pc=0xA0, then 0xA1. Repeat with jmp_nz=1, dont_jmp=1 at pc=0x05 -> next pc=0x06.
- Call/return: call=1, nibble=3 at pc=0x10 -> pc=0x30, stack holds 0x11. Later ret=1 at pc=0x34 -> pc=0x11. Nested calls to depth 4 return in LIFO order.
- Overflow: 5th call with 4 entries stacked -> stack_ovf=1, state FAULT, pc frozen for 20 cycles despite further jmp/ret. reset_n low -> flags clear, pc=0.
- Underflow: ret with empty stack at pc=0x07 -> stack_unf=1, FAULT, pc stays 0x07.
- Hold/wrap: pc=0xFF with hold high for 3 cycles -> pc stays 0xFF, fetch_valid=0. On release -> pc=0x00 with no flag. hold=1 coincident with jmp -> jump ignored.
